// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery for the Tiny VGA Pmod bus: locks after two matching frames.
// Optional per-frame CRC-16-CCITT of captured pixels is built only when FRAME_CRC_EN is defined.
`timescale 1ns/1ps
module vga_sync_decoder #(
  parameter int unsigned H_START  = 144,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_START  = 35,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic [5:0]  rgb,
  output logic        pixel_valid,
  output logic        locked,
  output logic        frame_done,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total,
  output logic [15:0] frame_crc
);

  localparam logic [9:0] H_LO    = 10'(H_START);
  localparam logic [9:0] H_HI    = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_LO    = 10'(V_START);
  localparam logic [9:0] V_HI    = 10'(V_START + V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_t;

  logic [7:0] s1_q, s2_q;
  logic       hs_edge, vs_edge;
  logic [9:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d, lcnt_base;
  logic [9:0] h_meas, h_tot_q, h_tot_d, v_tot_q, ref_v_q;
  logic       line_err_q, fd_pulse_q;
  state_t     state_q;
  logic       in_win;
  logic [5:0] rgb_pix;

  logic [9:0] hpos_q, vpos_q, h_total_q, v_total_q;
  logic [5:0] rgb_q;
  logic       pv_q, locked_q, frame_done_q;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= vga_in;
      s2_q <= s1_q;
    end
  end

  assign hs_edge = s2_q[7] & ~s1_q[7];
  assign vs_edge = s2_q[3] & ~s1_q[3];

  // Bus order is interleaved; regroup into {R1,R0,G1,G0,B1,B0}.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rgb
    assign rgb_pix[2*(2-gi)+1] = s2_q[gi];
    assign rgb_pix[2*(2-gi)]   = s2_q[gi+4];
  end

  always_comb begin
    h_meas    = sat_inc(hcnt_q);
    hcnt_d    = hs_edge ? 10'd0 : h_meas;
    h_tot_d   = hs_edge ? h_meas : h_tot_q;
    // A vsync edge clears first, so a coincident hsync edge leaves lcnt at 1.
    lcnt_base = vs_edge ? 10'd0 : lcnt_q;
    lcnt_d    = hs_edge ? sat_inc(lcnt_base) : lcnt_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      h_tot_q <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      h_tot_q <= h_tot_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      ref_v_q    <= '0;
      v_tot_q    <= '0;
      line_err_q <= 1'b0;
      fd_pulse_q <= 1'b0;
    end else begin
      fd_pulse_q <= 1'b0;
      case (state_q)
        SEARCH: if (vs_edge) state_q <= MEASURE;
        MEASURE: if (vs_edge) begin
          state_q    <= CHECK;
          ref_v_q    <= lcnt_q;
          line_err_q <= 1'b0;
        end
        CHECK: if (vs_edge) begin
          v_tot_q    <= lcnt_q;
          line_err_q <= 1'b0;
          if (lcnt_q == ref_v_q && lcnt_q != 10'd0 && !line_err_q) begin
            state_q    <= LOCKED;
            fd_pulse_q <= 1'b1;
          end else begin
            ref_v_q <= lcnt_q;
          end
        end
        LOCKED: begin
          if (vs_edge) v_tot_q <= lcnt_q;
          if (line_err_q || hcnt_q == CNT_MAX || (vs_edge && lcnt_q != ref_v_q))
            state_q <= SEARCH;
          else if (vs_edge)
            fd_pulse_q <= 1'b1;
        end
        default: state_q <= SEARCH;
      endcase
      // A length mismatch wins over a same-cycle clear.
      if (hs_edge && h_meas != h_tot_q) line_err_q <= 1'b1;
    end
  end

  assign in_win = (hcnt_q >= H_LO) && (hcnt_q < H_HI) &&
                  (lcnt_q >= V_LO) && (lcnt_q < V_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q       <= '0;
      vpos_q       <= '0;
      rgb_q        <= '0;
      pv_q         <= 1'b0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      h_total_q    <= '0;
      v_total_q    <= '0;
    end else begin
      rgb_q        <= rgb_pix;
      pv_q         <= (state_q == LOCKED) && in_win;
      locked_q     <= (state_q == LOCKED);
      frame_done_q <= fd_pulse_q;
      h_total_q    <= h_tot_q;
      v_total_q    <= v_tot_q;
      if (in_win) begin
        hpos_q <= hcnt_q - H_LO;
        vpos_q <= lcnt_q - V_LO;
      end
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign rgb         = rgb_q;
  assign pixel_valid = pv_q;
  assign locked      = locked_q;
  assign frame_done  = frame_done_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;

`ifdef FRAME_CRC_EN
  logic [15:0] crc_run_q, frame_crc_q;

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [5:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 5; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_run_q   <= 16'hFFFF;
      frame_crc_q <= '0;
    end else if (!locked_q) begin
      crc_run_q <= 16'hFFFF;
    end else if (frame_done_q) begin
      frame_crc_q <= crc_run_q;
      crc_run_q   <= 16'hFFFF;
    end else if (pv_q) begin
      crc_run_q <= crc_step(crc_run_q, rgb_q);
    end
  end

  assign frame_crc = frame_crc_q;
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled 24x12 timing stream (8x6 active).
`timescale 1ns/1ps
module tb_vga_sync_decoder;
  localparam int HT = 24, HA = 8, HS0 = 12, HS1 = 15;
  localparam int VT = 12, VA = 6, VS0 = 8;
  localparam int H_ST = HT - HS0;
  localparam int V_ST = VT - VS0;

  logic        clk;
  logic        rst_n;
  logic [7:0]  vga_in;
  logic [9:0]  hpos, vpos, h_total, v_total;
  logic [5:0]  rgb;
  logic        pixel_valid, locked, frame_done;
  logic [15:0] frame_crc;
  logic [15:0] exp_crc;

  int checks = 0;
  int errors = 0;
  int cur_f = 0, cur_l = 0, cur_c = 0;
  int short_f = -1, short_l = -1;

  vga_sync_decoder #(
    .H_START(H_ST), .H_ACTIVE(HA), .V_START(V_ST), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_in),
    .hpos(hpos), .vpos(vpos), .rgb(rgb), .pixel_valid(pixel_valid),
    .locked(locked), .frame_done(frame_done),
    .h_total(h_total), .v_total(v_total), .frame_crc(frame_crc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  function automatic logic [5:0] pat(input int l, input int c);
    if (l == 0 && c == 0) return 6'b110001;
    return 6'((((l * 8) + c) * 5 + 3) % 64);
  endfunction

  function automatic logic [7:0] bus_val(input int l, input int c);
    logic [5:0] p;
    logic [7:0] b;
    p = (l < VA && c < HA) ? pat(l, c) : 6'd0;
    b[0] = p[5]; b[4] = p[4];
    b[1] = p[3]; b[5] = p[2];
    b[2] = p[1]; b[6] = p[0];
    b[3] = (l >= VS0 && l <= VS0 + 1) ? 1'b0 : 1'b1;
    b[7] = (c >= HS0 && c <= HS1) ? 1'b0 : 1'b1;
    return b;
  endfunction

  function automatic logic [15:0] crc_model();
    logic [15:0] crc;
    logic [5:0]  p;
    logic        fb;
    crc = 16'hFFFF;
    for (int l = 0; l < VA; l++)
      for (int c = 0; c < HA; c++) begin
        p = pat(l, c);
        for (int i = 5; i >= 0; i--) begin
          fb  = crc[15] ^ p[i];
          crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
      end
    return crc;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    int len;
    vga_in = bus_val(cur_l, cur_c);
    @(posedge clk);
    #1;
    len = (cur_f == short_f && cur_l == short_l) ? HT - 1 : HT;
    cur_c++;
    if (cur_c >= len) begin
      cur_c = 0;
      cur_l++;
      if (cur_l >= VT) begin
        cur_l = 0;
        cur_f++;
      end
    end
  endtask

  task automatic step3();
    step(); step(); step();
  endtask

  task automatic run_to(input int f, input int l, input int c);
    int n = 0;
    while (!(cur_f == f && cur_l == l && cur_c == c) && n < 20000) begin
      step();
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $error("FAIL seek observed=%0d expected=%0d", cur_f * 10000 + cur_l * 100 + cur_c,
             f * 10000 + l * 100 + c);
    end
  endtask

  task automatic hold_raw(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) begin
      vga_in = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_locked"}, 32'(locked), 0);
    check({pfx, "_pv"}, 32'(pixel_valid), 0);
    check({pfx, "_fdone"}, 32'(frame_done), 0);
    check({pfx, "_hpos"}, 32'(hpos), 0);
    check({pfx, "_vpos"}, 32'(vpos), 0);
    check({pfx, "_rgb"}, 32'(rgb), 0);
    check({pfx, "_htotal"}, 32'(h_total), 0);
    check({pfx, "_vtotal"}, 32'(v_total), 0);
    check({pfx, "_crc"}, 32'(frame_crc), 0);
  endtask

  initial begin
    rst_n  = 1'b1;
    vga_in = 8'h88;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Three full-width 800-clock lines, hsync low for clocks 656..751.
    for (int k = 0; k < 3; k++) begin
      hold_raw(656, 8'h88);
      hold_raw(96, 8'h08);
      hold_raw(48, 8'h88);
    end
    check("htotal_800", 32'(h_total), 800);
    check("no_lock_raw", 32'(locked), 0);

    // Scaled stream: lock follows the third vsync edge.
    run_to(2, VS0, 0);
    step(); step();
    check("lock_pre", 32'(locked), 0);
    step();
    check("lock_rise", 32'(locked), 1);
    check("lock_fdone", 32'(frame_done), 1);
    check("lock_htotal", 32'(h_total), HT);
    check("lock_vtotal", 32'(v_total), VT);
    step();
    check("fdone_pulse_end", 32'(frame_done), 0);

    run_to(2, VT - 1, HT - 1);
    step3();
    check("pre_first_pv", 32'(pixel_valid), 0);
    step();
    check("first_hpos", 32'(hpos), 0);
    check("first_vpos", 32'(vpos), 0);
    check("first_rgb", 32'(rgb), 49);
    check("first_pv", 32'(pixel_valid), 1);
    step();
    check("second_hpos", 32'(hpos), 1);
    check("second_rgb", 32'(rgb), 8);

    run_to(3, VA - 1, HA - 1);
    step3();
    check("last_hpos", 32'(hpos), HA - 1);
    check("last_vpos", 32'(vpos), VA - 1);
    check("last_rgb", 32'(rgb), 46);
    check("last_pv", 32'(pixel_valid), 1);
    step();
    check("after_last_pv", 32'(pixel_valid), 0);
    check("after_last_hold", 32'(hpos), HA - 1);

    run_to(3, VS0, 0);
    step3();
    check("locked_fdone", 32'(frame_done), 1);
    check("locked_stay", 32'(locked), 1);
    step3();
`ifdef FRAME_CRC_EN
    exp_crc = crc_model();
`else
    exp_crc = 16'h0000;
`endif
    check("frame_crc", 32'(frame_crc), 32'(exp_crc));

    // One line of frame 4 is a clock short.
    short_f = 4;
    short_l = 2;
    run_to(4, 1, 0);
    step3();
    check("short_pre_locked", 32'(locked), 1);
    run_to(4, 4, 0);
    step3();
    check("short_unlock", 32'(locked), 0);
    check("short_pv", 32'(pixel_valid), 0);
    check("short_htotal", 32'(h_total), HT - 1);
    run_to(5, VS0, 0);
    step3();
    check("short_relock_2nd", 32'(locked), 0);
    run_to(6, VS0, 0);
    step3();
    check("short_relock_3rd", 32'(locked), 1);

    // Hsync held high long enough to saturate the line counter.
    run_to(7, 1, 0);
    check("hold_pre_locked", 32'(locked), 1);
    hold_raw(1100, 8'h88);
    check("hold_unlock", 32'(locked), 0);
    check("hold_pv", 32'(pixel_valid), 0);
    run_to(7, 1, HS0);
    step3();
    check("hold_htotal_sat", 32'(h_total), 1023);
    run_to(9, VS0, 0);
    step3();
    check("hold_relock", 32'(locked), 1);

    // Asynchronous reset in the middle of an active line.
    run_to(10, 2, 3);
    step3();
    check("pre_reset_pv", 32'(pixel_valid), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    step(); step();
    rst_n = 1'b1;
    run_to(11, VS0, 0);
    step3();
    check("reacq_2nd", 32'(locked), 0);
    run_to(12, VS0, 0);
    step3();
    check("reacq_3rd", 32'(locked), 1);
    check("reacq_vtotal", 32'(v_total), VT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing/pixel generator. Samples the 8-bit Tiny VGA Pmod bus (as driven on uo_out), recovers line and frame timing from hsync/vsync, and locks after two identical frames. Once locked, it outputs the pixel coordinate and 2-bit RGB for every active pixel, plus measured line and frame totals. Used as an on-chip loopback checker and as the bench's capture front end.

## Interface
- H_START, 144: clocks from hsync leading edge to first active pixel of the line.
- H_ACTIVE, 640: active pixels per line.
- V_START, 35: hsync leading edges from vsync leading edge to first active line.
- V_ACTIVE, 480: active lines per frame.
- clk  input  1  pixel clock, shared with the generator.
- rst_n  input  1  asynchronous active-low reset.
- vga_in  input  8  Pmod bus: [0]=R1 [1]=G1 [2]=B1 [3]=vsync [4]=R0 [5]=G0 [6]=B0 [7]=hsync.
- hpos  output  10  recovered X coordinate, valid when pixel_valid is high.
- vpos  output  10  recovered Y coordinate, valid when pixel_valid is high.
- rgb  output  6  {R1,R0,G1,G0,B1,B0} of the current pixel.
- pixel_valid  output  1  active pixel and locked.
- locked  output  1  timing lock.
- frame_done  output  1  one-cycle pulse at each vsync leading edge while locked.
- h_total  output  10  clocks between the last two hsync leading edges, saturating at 1023.
- v_total  output  10  hsync leading edges in the last complete frame, saturating at 1023.
- frame_crc  output  16  CRC of the last locked frame (see Configuration).

## Operation
- Syncs are active-low. A leading edge is a 1→0 transition of the registered sync bit.
- Input stage: vga_in is registered into s1, then s2. Edges are detected as s2=1 and s1=0.
- hcnt (10 bit):
  - Cleared to 0 on an hsync leading edge, otherwise incremented, saturating at 1023.
  - On each edge: h_total ← hcnt+1 (saturating); that value is compared with the previous h_total.
  - A mismatch sets line_err.
- lcnt (10 bit):
  - Cleared to 0 on a vsync leading edge; incremented (saturating) on each hsync leading edge.
  - If both edges fall in the same cycle, the clear is applied first and lcnt becomes 1.
- Lock FSM. States SEARCH, MEASURE, CHECK, LOCKED. Reset state is SEARCH.
  - SEARCH → MEASURE on a vsync edge.
  - MEASURE → CHECK on a vsync edge. ref_v ← lcnt; line_err cleared.
  - CHECK on a vsync edge: if lcnt==ref_v, lcnt≠0 and !line_err, go to LOCKED. Otherwise ref_v ← lcnt and stay in CHECK. line_err is cleared in both cases.
  - LOCKED → SEARCH on any of: a vsync edge with lcnt≠ref_v; line_err set; hcnt reaching 1023 (sync loss).
  - On a vsync edge in CHECK or LOCKED, v_total ← lcnt.
- locked = (state==LOCKED).
- Active window: hcnt ∈ [H_START, H_START+H_ACTIVE) and lcnt ∈ [V_START, V_START+V_ACTIVE).
  - In the window: hpos = hcnt−H_START, vpos = lcnt−V_START (10-bit).
  - Outside the window, hpos and vpos hold their last values.
- pixel_valid = locked & in window. rgb is always the delayed input colour; it is only meaningful when pixel_valid is high.

## Timing
- Reset values: every output is 0. State is SEARCH, counters are 0, line_err is 0.
- Latency:
  - A pixel on vga_in at cycle t appears on rgb/hpos/vpos/pixel_valid at t+3 (s1, s2, output register).
  - If an hsync leading edge is first present on vga_in at cycle e, the pixel on vga_in at e+H_START has hpos=0.
- locked rises and falls 3 cycles after the triggering vsync edge appears on vga_in; frame_done uses the same alignment.
- frame_done fires at the edge that enters LOCKED. It does not fire at the edge that leaves LOCKED.
- h_total and v_total update in the same cycle as the triggering edge's output alignment.
- Reset asserted mid-frame clears everything immediately. Lock reacquisition then needs three further vsync edges.

## Configuration
- FRAME_CRC_EN defined:
  - Computes CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) over rgb for each pixel_valid cycle.
  - frame_crc latches the running value at frame_done; the running CRC then reinitialises to 0xFFFF.
  - The running CRC also reinitialises whenever locked is low.
- FRAME_CRC_EN undefined: frame_crc is tied to 16'h0000 and no CRC logic is built.

## Test plan
- 800×525 generator stream (hsync low 656–751, vsync low on lines 490–491) from reset → locked rises after the 3rd vsync edge; h_total=800, v_total=525.
- Locked stream, pixel at line 0 col 0 = 6'b11_00_01 → output at +3 cycles shows hpos=0, vpos=0, rgb=6'b110001, pixel_valid=1. Last pixel gives hpos=639, vpos=479.
- Locked stream, one line shortened to 799 clocks → line_err set, locked drops, pixel_valid=0; relock after 3 clean vsync edges.
- Hold hsync high for 1100 clocks while locked → hcnt saturates at 1023, locked drops, h_total=1023 at the next edge.
- Reset pulse mid-frame → all outputs 0 within one cycle of assertion, state SEARCH.
- FRAME_CRC_EN with an all-zero frame → frame_crc equals the model CRC of 307200 zero 6-bit symbols. Without the macro → frame_crc=0.
